// File: rtl/sparse_arith_pkg.sv
// Shared helpers for the sparse arithmetic datapath: index sizing, popcount
// and the compactor FSM state type.
package sparse_arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } nzc_state_e;

    // Block index width; a single-block beat still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c += {31'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/nzc_thresh_block.sv
// Zero test for one block: every element magnitude must be at most threshold.
module nzc_thresh_block #(
    parameter int IN_WIDTH = 32,
    parameter int IN_SIZE  = 4
) (
    input  logic signed [IN_WIDTH-1:0] elems [IN_SIZE],
    input  logic        [IN_WIDTH-1:0] threshold,
    output logic                       zero_flag
);

    // One extra bit so the most negative element keeps its true magnitude.
    function automatic logic [IN_WIDTH:0] magnitude(input logic signed [IN_WIDTH-1:0] x);
        logic signed [IN_WIDTH:0] ext;
        ext = x;
        return x[IN_WIDTH-1] ? $unsigned(-ext) : $unsigned(ext);
    endfunction

    always_comb begin
        zero_flag = 1'b1;
        for (int e = 0; e < IN_SIZE; e++) begin
            if (magnitude(elems[e]) > {1'b0, threshold}) begin
                zero_flag = 1'b0;
            end
        end
    end

endmodule

// File: rtl/nzc_block_compactor.sv
// Streaming block-sparsity compactor: forwards only the non-zero blocks of each
// input beat, one per cycle with their index, and counts the skipped blocks.
module nzc_block_compactor
    import sparse_arith_pkg::*;
#(
    parameter int IN_WIDTH       = 32,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 4,
    parameter int COUNT_WIDTH    = 16,
    localparam int IDX_WIDTH     = idx_width(IN_PARALLELISM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic        [IN_WIDTH-1:0]    threshold,
    input  logic signed [IN_WIDTH-1:0]    data_in [IN_SIZE*IN_PARALLELISM],
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic signed [IN_WIDTH-1:0]    data_out [IN_SIZE],
    output logic        [IDX_WIDTH-1:0]   data_out_idx,
    output logic                          data_out_last,
    output logic                          data_out_empty,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    input  logic                          stats_clear,
    output logic        [COUNT_WIDTH-1:0] skip_count
);

    localparam int N_ELEMS = IN_SIZE * IN_PARALLELISM;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

    function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                       input int unsigned inc);
        logic [63:0] sum;
        sum = 64'(a) + 64'(inc);
        return (sum > 64'(CNT_MAX)) ? CNT_MAX : sum[COUNT_WIDTH-1:0];
    endfunction

    nzc_state_e                  state_p0, state_nxt;
    logic [IN_PARALLELISM-1:0]   zero_flags;
    logic [IN_PARALLELISM-1:0]   mask_p0, mask_rest;
    logic signed [IN_WIDTH-1:0]  data_p0 [N_ELEMS];
    logic signed [IN_WIDTH-1:0]  sel_blk [IN_SIZE];
    logic [IDX_WIDTH-1:0]        sel_idx;
    logic [COUNT_WIDTH-1:0]      skip_p0;
    logic                        in_hs, out_hs;

    for (genvar b = 0; b < IN_PARALLELISM; b++) begin : g_blk
        logic signed [IN_WIDTH-1:0] blk [IN_SIZE];
        always_comb begin
            for (int e = 0; e < IN_SIZE; e++) begin
                blk[e] = data_in[b*IN_SIZE + e];
            end
        end
        nzc_thresh_block #(
            .IN_WIDTH (IN_WIDTH),
            .IN_SIZE  (IN_SIZE)
        ) u_thresh (
            .elems     (blk),
            .threshold (threshold),
            .zero_flag (zero_flags[b])
        );
    end

    // Lowest pending block wins; mask_rest is the mask after it is consumed.
    always_comb begin
        sel_idx = '0;
        for (int b = IN_PARALLELISM - 1; b >= 0; b--) begin
            if (mask_p0[b]) sel_idx = IDX_WIDTH'(b);
        end
        mask_rest = mask_p0 & (mask_p0 - IN_PARALLELISM'(1));
        for (int e = 0; e < IN_SIZE; e++) sel_blk[e] = '0;
        for (int b = 0; b < IN_PARALLELISM; b++) begin
            if (sel_idx == IDX_WIDTH'(b)) begin
                for (int e = 0; e < IN_SIZE; e++) sel_blk[e] = data_p0[b*IN_SIZE + e];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_p0 <= IDLE;
        else     state_p0 <= state_nxt;
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE:    if (in_hs) state_nxt = EMIT;
            EMIT:    if (out_hs && data_out_last && !in_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // An all-zero beat still yields one marker beat so downstream sees every input.
    always_comb begin
        data_out_valid = (state_p0 == EMIT);
        data_out_empty = data_out_valid && (mask_p0 == '0);
        data_out_last  = data_out_valid && (mask_rest == '0);
        data_out_idx   = data_out_valid ? sel_idx : '0;
        for (int e = 0; e < IN_SIZE; e++) begin
            data_out[e] = (data_out_valid && !data_out_empty) ? sel_blk[e] : '0;
        end
        out_hs        = data_out_valid & data_out_ready;
        data_in_ready = (state_p0 == IDLE) | (out_hs & data_out_last);
        in_hs         = data_in_valid & data_in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_p0 <= '0;
            skip_p0 <= '0;
        end else begin
            if (in_hs)       mask_p0 <= ~zero_flags;
            else if (out_hs) mask_p0 <= mask_rest;
            if (stats_clear) skip_p0 <= '0;
            else if (in_hs)  skip_p0 <= sat_add(skip_p0, popcount(64'(zero_flags)));
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs) data_p0 <= data_in;
    end

    assign skip_count = skip_p0;

endmodule

// File: tb/tb_nzc_block_compactor.sv
// Bench for nzc_block_compactor: directed cases plus randomized traffic checked
// against a queue-based model of the expected output beats.
module tb_nzc_block_compactor;

    localparam int W    = 8;
    localparam int S    = 4;
    localparam int P    = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic                clk = 1'b0;
    logic                rst;
    logic [W-1:0]        threshold;
    logic signed [W-1:0] data_in [S*P];
    logic                data_in_valid;
    logic                data_in_ready;
    logic signed [W-1:0] data_out [S];
    logic [1:0]          data_out_idx;
    logic                data_out_last;
    logic                data_out_empty;
    logic                data_out_valid;
    logic                data_out_ready;
    logic                stats_clear;
    logic [CW-1:0]       skip_count;

    nzc_block_compactor #(
        .IN_WIDTH       (W),
        .IN_SIZE        (S),
        .IN_PARALLELISM (P),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .threshold      (threshold),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_idx   (data_out_idx),
        .data_out_last  (data_out_last),
        .data_out_empty (data_out_empty),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .stats_clear    (stats_clear),
        .skip_count     (skip_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        bit          last;
        bit          empty;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    exp_cnt;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit elem_zero(input logic signed [W-1:0] x, input logic [W-1:0] thr);
        int v, m;
        v = int'(x);
        m = (v < 0) ? -v : v;
        return m <= int'({24'b0, thr});
    endfunction

    function automatic logic [31:0] pack_out();
        return {data_out[3], data_out[2], data_out[1], data_out[0]};
    endfunction

    // Model: each accepted beat becomes a list of expected output beats.
    always @(posedge clk) begin : model
        bit    ohs, ihs, zero;
        int    z;
        int    nz[$];
        beat_t bt;
        if (rst) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            ohs = (exp_q.size() > 0) && data_out_ready;
            ihs = data_in_valid && ((exp_q.size() == 0) || (exp_q[0].last && data_out_ready));
            if (ohs) void'(exp_q.pop_front());
            z = 0;
            if (ihs) begin
                nz.delete();
                for (int b = 0; b < P; b++) begin
                    zero = 1'b1;
                    for (int e = 0; e < S; e++)
                        if (!elem_zero(data_in[b*S+e], threshold)) zero = 1'b0;
                    if (zero) z++;
                    else nz.push_back(b);
                end
                if (nz.size() == 0) begin
                    bt.idx = 0; bt.last = 1'b1; bt.empty = 1'b1; bt.data = 32'h0;
                    exp_q.push_back(bt);
                end else begin
                    for (int i = 0; i < nz.size(); i++) begin
                        bt.idx   = nz[i];
                        bt.last  = (i == nz.size() - 1);
                        bt.empty = 1'b0;
                        bt.data  = {data_in[nz[i]*S+3], data_in[nz[i]*S+2],
                                    data_in[nz[i]*S+1], data_in[nz[i]*S+0]};
                        exp_q.push_back(bt);
                    end
                end
            end
            if (stats_clear) exp_cnt = 0;
            else if (ihs)    exp_cnt = (exp_cnt + z > CMAX) ? CMAX : exp_cnt + z;
        end
    end

    always @(negedge clk) begin : compare
        bit ev, er;
        ev = exp_q.size() > 0;
        er = !ev || (exp_q[0].last && data_out_ready);
        chk("out_valid", longint'(data_out_valid), longint'(ev));
        chk("in_ready", longint'(data_in_ready), longint'(er));
        chk("skip_count", longint'(skip_count), longint'(exp_cnt));
        if (ev && data_out_valid) begin
            chk("out_idx", longint'(data_out_idx), longint'(exp_q[0].idx));
            chk("out_last", longint'(data_out_last), longint'(exp_q[0].last));
            chk("out_empty", longint'(data_out_empty), longint'(exp_q[0].empty));
            chk("out_data", longint'(pack_out()), longint'(exp_q[0].data));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_data();
        for (int i = 0; i < S*P; i++) data_in[i] = '0;
    endtask

    task automatic set_block(input int b, input int e0, input int e1, input int e2, input int e3);
        data_in[b*S+0] = W'(e0);
        data_in[b*S+1] = W'(e1);
        data_in[b*S+2] = W'(e2);
        data_in[b*S+3] = W'(e3);
    endtask

    task automatic send_one();
        data_in_valid = 1'b1;
        cyc();
        data_in_valid = 1'b0;
    endtask

    function automatic logic signed [W-1:0] rand_elem();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)  return '0;
        if (r < 8)  return W'(int'($urandom_range(0, 8)) - 4);
        if (r == 8) return ($urandom_range(0, 1) == 1) ? W'(-128) : W'(127);
        return W'($urandom);
    endfunction

    initial begin
        rst = 1'b1; threshold = '0; data_in_valid = 1'b0; data_out_ready = 1'b1;
        stats_clear = 1'b0;
        clear_data();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(data_out_valid), 0);
        chk("rst_in_ready", longint'(data_in_ready), 1);
        chk("rst_skip", longint'(skip_count), 0);
        chk("rst_idx", longint'(data_out_idx), 0);
        chk("rst_last", longint'(data_out_last), 0);
        chk("rst_empty", longint'(data_out_empty), 0);
        chk("rst_data", longint'(pack_out()), 0);
        rst = 1'b0;
        cyc();

        // Blocks [0,X,0,Y] with exact-zero threshold.
        threshold = 8'd0; clear_data();
        set_block(1, 5, 0, 0, 0); set_block(3, 0, 0, -1, 0);
        send_one();
        chk("t1_idx_a", longint'(data_out_idx), 1);
        chk("t1_last_a", longint'(data_out_last), 0);
        chk("t1_data_a", longint'(pack_out()), longint'(32'h0000_0005));
        chk("t1_in_ready_a", longint'(data_in_ready), 0);
        chk("t1_skip", longint'(skip_count), 2);
        cyc();
        chk("t1_idx_b", longint'(data_out_idx), 3);
        chk("t1_last_b", longint'(data_out_last), 1);
        chk("t1_data_b", longint'(pack_out()), longint'(32'h00ff_0000));
        chk("t1_in_ready_b", longint'(data_in_ready), 1);
        cyc();
        chk("t1_idle", longint'(data_out_valid), 0);

        // All-zero beat gives a single empty marker.
        clear_data();
        send_one();
        chk("t2_empty", longint'(data_out_empty), 1);
        chk("t2_last", longint'(data_out_last), 1);
        chk("t2_idx", longint'(data_out_idx), 0);
        chk("t2_data", longint'(pack_out()), 0);
        chk("t2_skip", longint'(skip_count), 6);
        cyc();

        // Threshold boundaries.
        threshold = 8'd3; clear_data();
        set_block(0, 3, -3, 2, 0); set_block(1, -4, 0, 0, 0);
        send_one();
        chk("t3_idx", longint'(data_out_idx), 1);
        chk("t3_last", longint'(data_out_last), 1);
        chk("t3_skip", longint'(skip_count), 9);
        cyc();
        threshold = 8'd127; clear_data();
        set_block(0, -128, 0, 0, 0); set_block(1, 127, -127, 0, 0);
        send_one();
        chk("t3_minneg_idx", longint'(data_out_idx), 0);
        chk("t3_minneg_last", longint'(data_out_last), 1);
        chk("t3_minneg_empty", longint'(data_out_empty), 0);
        chk("t3_minneg_skip", longint'(skip_count), 12);
        cyc();

        // Saturation over five all-zero beats, back to back.
        threshold = 8'd0; clear_data();
        data_in_valid = 1'b1;
        repeat (5) cyc();
        data_in_valid = 1'b0;
        chk("t4_sat", longint'(skip_count), 15);
        cyc();

        // Clear wins over a simultaneous increment.
        stats_clear = 1'b1;
        send_one();
        stats_clear = 1'b0;
        chk("t5_clear", longint'(skip_count), 0);
        cyc();

        // Backpressure mid-beat, then a back-to-back second beat.
        clear_data();
        set_block(0, 1, 0, 0, 0); set_block(1, 0, 2, 0, 0); set_block(2, 0, 0, 3, 0);
        send_one();
        chk("t6_idx0", longint'(data_out_idx), 0);
        cyc();
        data_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t6_hold_idx", longint'(data_out_idx), 1);
            chk("t6_hold_data", longint'(pack_out()), longint'(32'h0000_0200));
            chk("t6_hold_valid", longint'(data_out_valid), 1);
            chk("t6_hold_in_ready", longint'(data_in_ready), 0);
            cyc();
        end
        data_out_ready = 1'b1;
        clear_data(); set_block(3, 0, 0, 0, 7);
        data_in_valid = 1'b1;
        cyc();
        chk("t6_idx2", longint'(data_out_idx), 2);
        chk("t6_last2", longint'(data_out_last), 1);
        chk("t6_in_ready_last", longint'(data_in_ready), 1);
        cyc();
        data_in_valid = 1'b0;
        chk("t6_b2b_valid", longint'(data_out_valid), 1);
        chk("t6_b2b_idx", longint'(data_out_idx), 3);
        chk("t6_b2b_data", longint'(pack_out()), longint'(32'h0700_0000));
        chk("t6_skip", longint'(skip_count), 4);
        cyc();

        // Reset while emitting drops the held beat.
        clear_data();
        set_block(0, 1, 0, 0, 0); set_block(1, 1, 0, 0, 0); set_block(2, 1, 0, 0, 0);
        send_one();
        chk("t7_valid_before", longint'(data_out_valid), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t7_valid_after", longint'(data_out_valid), 0);
        chk("t7_skip_after", longint'(skip_count), 0);
        cyc();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 299) == 0);
            stats_clear    = ($urandom_range(0, 29) == 0);
            data_out_ready = ($urandom_range(0, 9) < 7);
            data_in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       threshold = 8'd127;
                1:       threshold = W'($urandom);
                default: threshold = W'($urandom_range(0, 4));
            endcase
            for (int k = 0; k < S*P; k++) data_in[k] = rand_elem();
            cyc();
        end
        rst = 1'b0; stats_clear = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b1;
        repeat (10) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
